// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle between a client and the serial adder
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder, DIGIT bits per cycle, registered sum/carry/overflow
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input logic           clk,
   input logic           rst_n,
   serial_adder_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 1 || WIDTH > 64 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_adder: WIDTH must be 1..64 and a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [DIGIT:0]   dsum;
   logic [WIDTH-1:0] res_next;
   logic             msb_cin;

   // The final digit's sum MSB and operand MSBs recover the carry into bit WIDTH-1.
   always_comb begin
      dsum     = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
      res_next = (res >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
      msb_cin  = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ dsum[DIGIT-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         a_sr         <= '0;
         b_sr         <= '0;
         res          <= '0;
         carry        <= 1'b0;
         cnt          <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.sum      <= '0;
         bus.cout     <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  a_sr     <= bus.a;
                  b_sr     <= bus.b;
                  carry    <= bus.cin;
                  res      <= '0;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_sr  <= a_sr >> DIGIT;
               b_sr  <= b_sr >> DIGIT;
               res   <= res_next;
               carry <= dsum[DIGIT];
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  bus.sum      <= res_next;
                  bus.cout     <= dsum[DIGIT];
                  bus.overflow <= msb_cin ^ dsum[DIGIT];
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed checks of serial_adder at 1x1, 8x1 and 8x4 configurations
module tb_serial_adder;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(1)) i1 ();
   serial_adder_if #(.WIDTH(8)) i8 ();
   serial_adder_if #(.WIDTH(8)) i84 ();

   serial_adder #(.WIDTH(1), .DIGIT(1)) u1  (.clk(clk), .rst_n(rst_n), .bus(i1));
   serial_adder #(.WIDTH(8), .DIGIT(1)) u8  (.clk(clk), .rst_n(rst_n), .bus(i8));
   serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (.clk(clk), .rst_n(rst_n), .bus(i84));

   logic [7:0] prev_sum [3];
   logic       prev_cout [3];
   logic       prev_ov [3];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b, input logic ci);
      case (sel)
         0: begin i1.start = st;  i1.a = a[0]; i1.b = b[0]; i1.cin = ci;  end
         1: begin i8.start = st;  i8.a = a;    i8.b = b;    i8.cin = ci;  end
         default: begin i84.start = st; i84.a = a; i84.b = b; i84.cin = ci; end
      endcase
   endtask

   task automatic set_start(input int sel, input logic st);
      case (sel)
         0: i1.start = st;
         1: i8.start = st;
         default: i84.start = st;
      endcase
   endtask

   task automatic sample(input int sel, output logic bz, output logic dn, output logic [7:0] s,
                         output logic co, output logic ov);
      case (sel)
         0: begin bz = i1.busy; dn = i1.done; s = {7'b0, i1.sum}; co = i1.cout; ov = i1.overflow; end
         1: begin bz = i8.busy; dn = i8.done; s = i8.sum; co = i8.cout; ov = i8.overflow; end
         default: begin bz = i84.busy; dn = i84.done; s = i84.sum; co = i84.cout; ov = i84.overflow; end
      endcase
   endtask

   // One addition; with hold set, start stays high and operands are scrambled through RUN.
   task automatic op(input int sel, input int n, input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic [7:0] es, input logic ec, input logic eo, input bit hold, input string tag);
      int   nbusy = 0;
      int   ndone = 0;
      int   done_at = -1;
      logic bz, dn, co, ov;
      logic [7:0] s;
      @(negedge clk);
      drive(sel, 1'b1, a, b, ci);
      @(negedge clk);
      if (!hold) set_start(sel, 1'b0);
      for (int i = 0; i < n + 4; i++) begin
         if (i > 0) @(negedge clk);
         sample(sel, bz, dn, s, co, ov);
         if (bz) nbusy++;
         if (i < n)
            check({tag, "_held"}, {54'b0, s, co, ov}, {54'b0, prev_sum[sel], prev_cout[sel], prev_ov[sel]});
         if (dn) begin
            ndone++;
            done_at = i;
            check({tag, "_sum"}, {56'b0, s}, {56'b0, es});
            check({tag, "_cout"}, {63'b0, co}, {63'b0, ec});
            check({tag, "_ovf"}, {63'b0, ov}, {63'b0, eo});
         end
         if (hold) begin
            if (i < n) drive(sel, 1'b1, ~a, ~b, ~ci);
            else       set_start(sel, 1'b0);
         end
      end
      check({tag, "_busy_cycles"}, 64'(nbusy), 64'(n));
      check({tag, "_done_pulses"}, 64'(ndone), 64'd1);
      check({tag, "_done_latency"}, 64'(done_at), 64'(n));
      prev_sum[sel]  = es;
      prev_cout[sel] = ec;
      prev_ov[sel]   = eo;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic       bz, dn, co, ov;
      logic [7:0] s;
      int         nd;
      logic [2:0] iv;
      // {cout, sum, overflow} for a,b,cin = index bits [2],[1],[0]
      logic [2:0] fa_tab [8] = '{3'b000, 3'b011, 3'b010, 3'b100, 3'b010, 3'b100, 3'b101, 3'b110};

      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(k, 1'b0, 8'h00, 8'h00, 1'b0);
         prev_sum[k] = 8'h00; prev_cout[k] = 1'b0; prev_ov[k] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         sample(k, bz, dn, s, co, ov);
         check($sformatf("reset_state_%0d", k), {52'b0, bz, dn, s, co, ov}, 64'd0);
      end
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         iv = 3'(i);
         op(0, 1, {7'b0, iv[2]}, {7'b0, iv[1]}, iv[0],
            {7'b0, fa_tab[i][1]}, fa_tab[i][2], fa_tab[i][0], 1'b0, $sformatf("fa%0d", i));
      end

      op(1, 8, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "w8_ff_01");
      op(1, 8, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, "w8_7f_01");
      op(1, 8, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, "w8_a5_5a");

      op(2, 2, 8'h3C, 8'h44, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, "w8d4_3c_44");
      op(2, 2, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "w8d4_ff_ff");

      op(1, 8, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1, "w8_hold");

      @(negedge clk);
      drive(1, 1'b1, 8'h55, 8'h22, 1'b0);
      @(negedge clk);
      set_start(1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      sample(1, bz, dn, s, co, ov);
      check("midrun_reset_busy", {63'b0, bz}, 64'd0);
      check("midrun_reset_outs", {54'b0, dn, s, co}, 64'd0);
      check("midrun_reset_ovf", {63'b0, ov}, 64'd0);
      for (int k = 0; k < 3; k++) begin
         prev_sum[k] = 8'h00; prev_cout[k] = 1'b0; prev_ov[k] = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         sample(1, bz, dn, s, co, ov);
         if (dn || bz) nd++;
      end
      check("abandoned_no_done", 64'(nd), 64'd0);

      op(1, 8, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "w8_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and set the operand width in bits; legal values are 1..64.
REQ-002 The parameter DIGIT SHALL default to 1 and set the bits added per cycle; it must divide WIDTH exactly, else elaboration fails.
REQ-003 The port clk SHALL be an input, 1 bit wide: the single clock, with all state updated on its rising edge.
REQ-004 The port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 The port start SHALL be an input, 1 bit wide: a request to begin an addition, sampled on the rising edge.
REQ-006 The port a SHALL be an input, WIDTH bits wide: operand A, captured when start is accepted.
REQ-007 The port b SHALL be an input, WIDTH bits wide: operand B, captured when start is accepted.
REQ-008 The port cin SHALL be an input, 1 bit wide: carry-in, captured when start is accepted.
REQ-009 The port busy SHALL be an output, 1 bit wide, high while the addition is in progress.
REQ-010 The port done SHALL be an output, 1 bit wide, giving a one-cycle pulse when the result is valid.
REQ-011 The port sum SHALL be an output, WIDTH bits wide: the registered result, mod 2^WIDTH.
REQ-012 The port cout SHALL be an output, 1 bit wide: the registered carry out of the MSB.
REQ-013 The port overflow SHALL be an output, 1 bit wide: registered two's-complement overflow (carry into MSB XOR carry out of MSB).

Function
REQ-014 N SHALL equal WIDTH/DIGIT, the number of processing cycles per addition.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE with start=1 at a rising edge, the block SHALL capture a, b and cin into internal shift registers, clear the digit counter, and enter RUN.
REQ-017 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-018 In RUN, each rising edge SHALL add the low DIGIT bits of the A and B shift registers plus the carry register.
REQ-019 Also on each RUN edge, the DIGIT-bit result SHALL be shifted into the internal result register from the MSB end, the operands shifted right by DIGIT, the carry register updated, and the counter incremented.
REQ-020 On the Nth RUN edge, the block SHALL transfer the full result to sum, the final carry to cout, and the overflow term to overflow, and enter DONE.
REQ-021 In DONE, the next rising edge SHALL return the block to IDLE unconditionally.
REQ-022 busy SHALL be 1 in RUN only, i.e. for exactly N cycles following the edge that accepted start.
REQ-023 done SHALL be 1 in DONE only, i.e. for exactly one cycle.
REQ-024 start SHALL be ignored in RUN and DONE; it is not queued.
REQ-025 a, b and cin changing after acceptance SHALL NOT affect the result in progress.
REQ-026 sum, cout and overflow SHALL change only on entry to DONE, and SHALL hold the previous result through IDLE and RUN.
REQ-027 The addition SHALL be exact: {cout,sum} == a + b + cin, computed in WIDTH+1 bits.
REQ-028 Latency SHALL be N+1 cycles from start acceptance to done high; throughput SHALL be one addition per N+2 cycles.

Reset
REQ-029 rst_n=0 SHALL, asynchronously and in any state including mid-RUN, force IDLE.
REQ-030 rst_n=0 SHALL drive busy=0, done=0, sum=0, cout=0 and overflow=0, and clear all internal registers.
REQ-031 An operation interrupted by reset SHALL be abandoned with no done pulse.
REQ-032 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-033 With WIDTH=1, DIGIT=1, the bench SHALL apply all 8 combinations of a/b/cin -> {cout,sum} matches the full-adder truth table; done appears 2 cycles after each start.
REQ-034 With WIDTH=8, DIGIT=1: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0; busy high 8 cycles; done pulses once.
REQ-035 With WIDTH=8, DIGIT=1: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, overflow=1; then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1, overflow=0.
REQ-036 With WIDTH=8, DIGIT=4: a=8'h3C, b=8'h44, cin=0 -> sum=8'h80, overflow=1; busy high exactly 2 cycles.
REQ-037 With start held high through RUN and operands changed mid-run -> exactly one done per accepted start; the result reflects the captured operands.
REQ-038 With rst_n pulsed low on the 3rd RUN cycle -> busy=0 and all outputs 0 immediately; no done pulse; a following start completes correctly.
